// File: rtl/status_spi_pkg.sv
// status_spi_pkg: shared state encoding and sizing for the status SPI transmitter.
package status_spi_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, OVERRUN} state_t;
    localparam int WORD_WIDTH_DEFAULT = 16;
    function automatic int cnt_width(input int w);
        return $clog2(w + 2);
    endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer with rise/fall event pulses on the synchronized level.
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic fpga_clock,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    always_ff @(posedge fpga_clock or posedge rst)
        if (rst) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
            prev <= sync[SYNC_STAGES-1];
        end
    assign rise = sync[SYNC_STAGES-1] & ~prev;
    assign fall = ~sync[SYNC_STAGES-1] & prev;
endmodule

// File: rtl/status_spi_tx.sv
// status_spi_tx: mode-0 SPI slave transmitter with double-buffered status word load.
// Optional MISO output enable via STATUS_SPI_TX_TRISTATE_EN.
module status_spi_tx
    import status_spi_pkg::*;
#(
    parameter int   WORD_WIDTH  = WORD_WIDTH_DEFAULT,
    parameter int   SYNC_STAGES = 2,
    parameter logic IDLE_LEVEL  = 1'b0
) (
    input  logic                  fpga_clock,
    input  logic                  rst,
    input  logic                  spi_nss,
    input  logic                  spi_clock_in,
    output logic                  spi_data_out,
`ifdef STATUS_SPI_TX_TRISTATE_EN
    output logic                  spi_data_oe,
`endif
    input  logic [WORD_WIDTH-1:0] data_in,
    input  logic                  load,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  frame_abort,
    output logic                  underrun
);
    localparam int CW = cnt_width(WORD_WIDTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(WORD_WIDTH);
    localparam logic [CW-1:0] MAX_CNT  = CW'(WORD_WIDTH + 1);

    state_t                state, state_nxt;
    logic                  nss_rise, nss_fall, sck_rise, sck_fall;
    logic [WORD_WIDTH-1:0] hold_q, shift_q;
    logic                  hold_full;
    logic [CW-1:0]         cnt;
    logic                  start;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_nss (
        .fpga_clock(fpga_clock), .rst(rst), .din(spi_nss), .rise(nss_rise), .fall(nss_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck (
        .fpga_clock(fpga_clock), .rst(rst), .din(spi_clock_in), .rise(sck_rise), .fall(sck_fall)
    );

    assign start = (state == IDLE) && nss_fall;

    always_ff @(posedge fpga_clock or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = nss_fall ? SHIFT : IDLE;
            SHIFT:   state_nxt = nss_rise ? IDLE : (sck_fall && cnt == FULL_CNT) ? OVERRUN : SHIFT;
            OVERRUN: state_nxt = nss_rise ? IDLE : OVERRUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy         = state != IDLE;
        spi_data_out = (state == SHIFT) ? shift_q[WORD_WIDTH-1] : IDLE_LEVEL;
`ifdef STATUS_SPI_TX_TRISTATE_EN
        spi_data_oe  = state != IDLE;
`endif
    end

    // hold_q keeps the last word sent, so an empty hold re-sends it on underrun
    always_ff @(posedge fpga_clock or posedge rst)
        if (rst) begin
            hold_q      <= '0;
            hold_full   <= 1'b0;
            shift_q     <= '0;
            cnt         <= '0;
            underrun    <= 1'b0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            frame_done  <= (state != IDLE) && nss_rise && cnt == FULL_CNT;
            frame_abort <= (state != IDLE) && nss_rise && cnt != FULL_CNT;
            if (load) hold_q <= data_in;
            if (start) begin
                shift_q   <= load ? data_in : hold_q;
                hold_full <= 1'b0;
                cnt       <= '0;
                underrun  <= load ? 1'b0 : (underrun | ~hold_full);
            end else begin
                if (load) begin
                    hold_full <= 1'b1;
                    underrun  <= 1'b0;
                end
                if (state != IDLE && nss_rise) cnt <= '0;
                else if (state == SHIFT && sck_rise && cnt != MAX_CNT) cnt <= cnt + 1'b1;
                if (state == SHIFT && !nss_rise && sck_fall && cnt < FULL_CNT)
                    shift_q <= {shift_q[WORD_WIDTH-2:0], 1'b0};
            end
        end
endmodule

// File: tb/tb_status_spi_tx.sv
// tb_status_spi_tx: directed frames from a modelled SPI master against hand-computed words.
`timescale 1ns/1ps
module tb_status_spi_tx;
    logic        fpga_clock = 1'b0;
    logic        rst = 1'b1;
    logic        spi_nss = 1'b1;
    logic        spi_clock_in = 1'b0;
    logic        spi_data_out;
    logic [15:0] data_in = '0;
    logic        load = 1'b0;
    logic        busy, frame_done, frame_abort, underrun;
`ifdef STATUS_SPI_TX_TRISTATE_EN
    logic        spi_data_oe;
`endif
    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int abort_cnt = 0;
    int d0, a0;
    logic [31:0] rx;
    logic        bsy;

    always #5.64 fpga_clock = ~fpga_clock;

    status_spi_tx dut (
        .fpga_clock(fpga_clock), .rst(rst), .spi_nss(spi_nss), .spi_clock_in(spi_clock_in),
        .spi_data_out(spi_data_out),
`ifdef STATUS_SPI_TX_TRISTATE_EN
        .spi_data_oe(spi_data_oe),
`endif
        .data_in(data_in), .load(load), .busy(busy), .frame_done(frame_done),
        .frame_abort(frame_abort), .underrun(underrun)
    );

    always @(negedge fpga_clock) begin
        if (frame_done)  done_cnt++;
        if (frame_abort) abort_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge fpga_clock);
    endtask

    task automatic load_word(input logic [15:0] w);
        @(negedge fpga_clock);
        data_in = w;
        load = 1'b1;
        @(negedge fpga_clock);
        load = 1'b0;
    endtask

    task automatic clk_bits(input int n, inout logic [31:0] r);
        for (int i = 0; i < n; i++) begin
            spi_clock_in = 1'b1;
            r = {r[30:0], spi_data_out};
            wait_cyc(9);
            spi_clock_in = 1'b0;
            wait_cyc(9);
        end
    endtask

    task automatic run_frame(input int n, output logic [31:0] r, output logic b);
        r = '0;
        spi_nss = 1'b0;
        wait_cyc(9);
        clk_bits(n, r);
        b = busy;
        spi_nss = 1'b1;
        wait_cyc(8);
    endtask

    initial begin
        wait_cyc(4);
        rst = 1'b0;
        wait_cyc(6);
        check("rst_miso", spi_data_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_abort", frame_abort, 0);
        check("rst_underrun", underrun, 0);

        load_word(16'hA5C3);
        d0 = done_cnt; a0 = abort_cnt;
        run_frame(16, rx, bsy);
        check("f1_word", rx, 32'h0000A5C3);
        check("f1_busy", bsy, 1);
        check("f1_busy_after", busy, 0);
        check("f1_done", done_cnt - d0, 1);
        check("f1_abort", abort_cnt - a0, 0);
        check("f1_underrun", underrun, 0);

        load_word(16'h1234);
        run_frame(16, rx, bsy);
        check("f2_word", rx, 32'h00001234);
        check("f2_underrun", underrun, 0);
        run_frame(16, rx, bsy);
        check("f3_resend", rx, 32'h00001234);
        check("f3_underrun", underrun, 1);
        load_word(16'h0001);
        check("underrun_clr", underrun, 0);

        load_word(16'hFFFF);
        load_word(16'h00F0);
        run_frame(16, rx, bsy);
        check("newest_wins", rx, 32'h000000F0);

        load_word(16'hABCD);
        d0 = done_cnt; a0 = abort_cnt;
        run_frame(7, rx, bsy);
        check("abort_bits", rx, 32'h00000055);
        check("abort_pulse", abort_cnt - a0, 1);
        check("abort_no_done", done_cnt - d0, 0);
        load_word(16'h5A5A);
        d0 = done_cnt;
        run_frame(16, rx, bsy);
        check("after_abort", rx, 32'h00005A5A);
        check("after_abort_done", done_cnt - d0, 1);

        load_word(16'hC3C3);
        d0 = done_cnt; a0 = abort_cnt;
        run_frame(18, rx, bsy);
        check("overrun_bits", rx, 32'h00030F0C);
        check("overrun_done", done_cnt - d0, 1);
        check("overrun_abort", abort_cnt - a0, 0);

        load_word(16'hFFFF);
        rx = '0;
        spi_nss = 1'b0;
        wait_cyc(9);
        clk_bits(9, rx);
        check("pre_rst_bits", rx, 32'h000001FF);
        rst = 1'b1;
        wait_cyc(3);
        check("midrst_miso", spi_data_out, 0);
        check("midrst_busy", busy, 0);
        rst = 1'b0;
        wait_cyc(2);
        d0 = done_cnt; a0 = abort_cnt;
        check("postrst_miso", spi_data_out, 0);
        check("postrst_busy", busy, 0);
        check("postrst_underrun", underrun, 0);
        rx = '0;
        clk_bits(4, rx);
        check("postrst_ignored", rx, 0);
        check("postrst_busy2", busy, 0);
        spi_nss = 1'b1;
        wait_cyc(8);
        check("postrst_no_pulse", (done_cnt - d0) + (abort_cnt - a0), 0);
        load_word(16'h4321);
        d0 = done_cnt;
        run_frame(16, rx, bsy);
        check("postrst_frame", rx, 32'h00004321);
        check("postrst_done", done_cnt - d0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
